// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: class codes, RV32I opcodes,
// FSM states and immediate range limits.
package instr_enc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 21;
  localparam int unsigned CLS_W   = 3;

  localparam logic [CLS_W-1:0] CLS_ALU_R  = 3'd0;
  localparam logic [CLS_W-1:0] CLS_ALU_I  = 3'd1;
  localparam logic [CLS_W-1:0] CLS_BRANCH = 3'd2;
  localparam logic [CLS_W-1:0] CLS_JUMP   = 3'd3;
  localparam logic [CLS_W-1:0] CLS_LOAD   = 3'd4;
  localparam logic [CLS_W-1:0] CLS_STORE  = 3'd5;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int IMM12_MIN  = -2048;
  localparam int IMM12_MAX  = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: decoded fields in, RV32I word and legality flag out.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [CLS_W-1:0]   cls,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [IMM_W-1:0]   imm,
  output logic [INSTR_W-1:0] word_c,
  output logic               illegal_c
);

  logic signed [IMM_W-1:0] imm_s;
  int                      imm_val;
  logic                    imm12_ok;
  logic                    immb_ok;

  assign imm_s    = $signed(imm);
  assign imm_val  = int'(imm_s);
  assign imm12_ok = (imm_val >= IMM12_MIN) && (imm_val <= IMM12_MAX);
  assign immb_ok  = (imm_val >= IMM_B_MIN) && (imm_val <= IMM_B_MAX) && !imm[0];

  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    case (cls)
      CLS_ALU_R: word_c = {funct7, rs2, rs1, funct3, rd, OP_ALU_R};
      CLS_ALU_I: begin
        word_c    = {imm[11:0], rs1, funct3, rd, OP_ALU_I};
        illegal_c = !imm12_ok;
      end
      CLS_LOAD: begin
        word_c    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        illegal_c = !imm12_ok;
      end
      CLS_STORE: begin
        word_c    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        illegal_c = !imm12_ok;
      end
      CLS_BRANCH: begin
        word_c    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        illegal_c = !immb_ok;
      end
      CLS_JUMP: begin
        // 21-bit field already spans the full JAL range; only alignment can fail
        word_c    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal_c = imm[0];
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: accepts field bundles, writes packed words to imem
// at consecutive addresses, and tracks program completion and errors.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLS_W-1:0]   in_class,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_last,
  output logic               imem_wen,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic [ADDR_W:0]    count,
  output logic               done,
  output logic               err
);

  enc_state_e           state;
  logic [INSTR_W-1:0]   word_c;
  logic                 illegal_c;
  logic [ADDR_W:0]      addr_sum;
  logic                 full;

  instr_field_pack u_pack (
    .cls       (in_class),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .imm       (in_imm),
    .word_c    (word_c),
    .illegal_c (illegal_c)
  );

  // count never exceeds 2^ADDR_W, so its MSB alone flags a full memory
  assign full     = count[ADDR_W];
  assign addr_sum = count + (ADDR_W+1)'(BASE_ADDR);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      imem_wen   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_wen <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_RUN;
            in_ready <= 1'b1;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (illegal_c || full) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              imem_wen   <= 1'b1;
              imem_addr  <= addr_sum[ADDR_W-1:0];
              imem_wdata <= word_c;
              count      <= count + (ADDR_W+1)'(1);
              if (in_last) begin
                state    <= ST_DRAIN;
                in_ready <= 1'b0;
              end
            end
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: single-instruction vector table plus
// streaming, wrap/overflow and async-reset sequences.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [20:0] in_imm;
  logic        in_last;

  logic        a_ready, a_wen, a_done, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [10:0] a_count;

  logic        s_ready, s_wen, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
    .clk(clk), .arst(arst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .imem_wen(a_wen), .imem_addr(a_addr), .imem_wdata(a_wdata), .count(a_count),
    .done(a_done), .err(a_err)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut_s (
    .clk(clk), .arst(arst), .start(start), .in_valid(in_valid), .in_ready(s_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .imem_wen(s_wen), .imem_addr(s_addr), .imem_wdata(s_wdata), .count(s_count),
    .done(s_done), .err(s_err)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] imm;
    logic [31:0] word;
    logic        bad;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [20:0] imm, input logic last);
    in_valid = 1'b1; in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{CLS_ALU_I,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(5),     32'h00500093, 1'b0};
    vec[1]  = '{CLS_LOAD,   5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 21'(12),    32'h00C12283, 1'b0};
    vec[2]  = '{CLS_STORE,  5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 21'(8),     32'h00512423, 1'b0};
    vec[3]  = '{CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'(3),     32'h0,        1'b1};
    vec[4]  = '{CLS_ALU_I,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(2048),  32'h0,        1'b1};
    vec[5]  = '{3'd7,       5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(0),     32'h0,        1'b1};
    vec[6]  = '{CLS_ALU_I,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'(-2048), 32'h80000013, 1'b0};
    vec[7]  = '{CLS_ALU_I,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'(2047),  32'h7FF00013, 1'b0};
    vec[8]  = '{CLS_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'(4094),  32'h7E000FE3, 1'b0};
    vec[9]  = '{CLS_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'(4096),  32'h0,        1'b1};
    vec[10] = '{CLS_JUMP,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(1),     32'h0,        1'b1};
    vec[11] = '{CLS_STORE,  5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 21'(-2049), 32'h0,        1'b1};
    vec[12] = '{3'd6,       5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(0),     32'h0,        1'b1};
    vec[13] = '{CLS_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'(-4096), 32'h80000063, 1'b0};

    arst = 1'b1; start = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0, 1'b0);
    idle_in();
    #12;
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_wen",   64'(a_wen),   64'd0);
    chk("rst_addr",  64'(a_addr),  64'd0);
    chk("rst_wdata", 64'(a_wdata), 64'd0);
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_done",  64'(a_done),  64'd0);
    chk("rst_err",   64'(a_err),   64'd0);
    arst = 1'b0;
    tick();

    // in_valid in IDLE is ignored
    drive(CLS_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd5, 1'b1);
    tick();
    chk("idle_ignore_wen", 64'(a_wen), 64'd0);
    idle_in();

    for (int i = 0; i < NV; i++) begin
      do_start();
      chk($sformatf("v%0d_start_ready", i), 64'(a_ready), 64'd1);
      chk($sformatf("v%0d_start_err", i),   64'(a_err),   64'd0);
      drive(vec[i].cls, vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].f3, vec[i].f7, vec[i].imm, 1'b1);
      tick();
      idle_in();
      if (vec[i].bad) begin
        chk($sformatf("v%0d_wen", i),   64'(a_wen),   64'd0);
        chk($sformatf("v%0d_err", i),   64'(a_err),   64'd1);
        chk($sformatf("v%0d_ready", i), 64'(a_ready), 64'd0);
        chk($sformatf("v%0d_count", i), 64'(a_count), 64'd0);
        tick();
        chk($sformatf("v%0d_done", i),  64'(a_done),  64'd0);
      end else begin
        chk($sformatf("v%0d_wen", i),   64'(a_wen),   64'd1);
        chk($sformatf("v%0d_addr", i),  64'(a_addr),  64'd0);
        chk($sformatf("v%0d_word", i),  64'(a_wdata), 64'(vec[i].word));
        chk($sformatf("v%0d_count", i), 64'(a_count), 64'd1);
        chk($sformatf("v%0d_done0", i), 64'(a_done),  64'd0);
        tick();
        chk($sformatf("v%0d_done", i),  64'(a_done),  64'd1);
        chk($sformatf("v%0d_wen_off", i), 64'(a_wen), 64'd0);
      end
    end

    // back-to-back stream of three words
    do_start();
    drive(CLS_ALU_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b0);
    tick();
    chk("s0_wen", 64'(a_wen), 64'd1);
    chk("s0_addr", 64'(a_addr), 64'd0);
    chk("s0_word", 64'(a_wdata), 64'h002081B3);
    drive(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'(-8), 1'b0);
    tick();
    chk("s1_wen", 64'(a_wen), 64'd1);
    chk("s1_addr", 64'(a_addr), 64'd1);
    chk("s1_word", 64'(a_wdata), 64'hFE208CE3);
    drive(CLS_JUMP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd8, 1'b1);
    tick();
    idle_in();
    chk("s2_wen", 64'(a_wen), 64'd1);
    chk("s2_addr", 64'(a_addr), 64'd2);
    chk("s2_word", 64'(a_wdata), 64'h008000EF);
    chk("s2_count", 64'(a_count), 64'd3);
    chk("s2_ready", 64'(a_ready), 64'd0);
    chk("s2_done", 64'(a_done), 64'd0);
    // start during DRAIN must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s_done", 64'(a_done), 64'd1);
    chk("s_count_hold", 64'(a_count), 64'd3);
    tick();
    chk("s_done_hold", 64'(a_done), 64'd1);

    // small memory: wrap around then overflow
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive(CLS_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'(i), 1'b0);
      tick();
      chk($sformatf("w%0d_wen", i), 64'(s_wen), 64'd1);
      chk($sformatf("w%0d_addr", i), 64'(s_addr), 64'((i + 2) % 4));
      chk($sformatf("w%0d_word", i), 64'(s_wdata), 64'((i << 20) | 32'h00000093));
      chk($sformatf("w%0d_count", i), 64'(s_count), 64'(i + 1));
    end
    drive(CLS_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd9, 1'b1);
    tick();
    idle_in();
    chk("ovf_wen", 64'(s_wen), 64'd0);
    chk("ovf_err", 64'(s_err), 64'd1);
    chk("ovf_count", 64'(s_count), 64'd4);
    chk("ovf_ready", 64'(s_ready), 64'd0);
    do_start();
    chk("ovf_clear_err", 64'(s_err), 64'd0);
    chk("ovf_clear_count", 64'(s_count), 64'd0);

    // async reset while a write is pending
    do_start();
    drive(CLS_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd5, 1'b0);
    tick();
    idle_in();
    chk("ar_pre_wen", 64'(a_wen), 64'd1);
    #2 arst = 1'b1;
    #1;
    chk("ar_wen", 64'(a_wen), 64'd0);
    chk("ar_count", 64'(a_count), 64'd0);
    chk("ar_ready", 64'(a_ready), 64'd0);
    chk("ar_wdata", 64'(a_wdata), 64'd0);
    #1 arst = 1'b0;
    tick();
    chk("ar_idle_ready", 64'(a_ready), 64'd0);
    chk("ar_idle_wen", 64'(a_wen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V instruction encoder: the inverse of the core's opcode decoder. Accepts one instruction per cycle as decoded fields (class, registers, funct bits, immediate), range-checks the fields, packs them into a 32-bit RV32I word and writes it to instruction memory at an auto-incrementing address. It sits between the testbench/program loader and the imem write port, producing programs for the single-cycle core covering the classes it decodes: ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD and STORE.

## Interface
- ADDR_W, 10, imem word-address width
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  clock, rising edge
- arst  in  1  asynchronous reset, active-high
- start  in  1  begin a new program; honoured only in IDLE, DONE or ERR
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_class  in  3  0 ALU_R, 1 ALU_I, 2 BRANCH_EQ, 3 JUMP, 4 LOAD, 5 STORE; 6–7 illegal
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  21  signed byte offset / immediate
- in_last  in  1  marks final instruction of the program
- imem_wen  out  1; imem_addr  out  ADDR_W; imem_wdata  out  32
- count  out  ADDR_W+1  words written since `start`
- done  out  1  program complete
- err  out  1  sticky error (illegal class, bad immediate, overflow)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE, ERR. Reset → IDLE.
- IDLE/DONE/ERR, start=1 → RUN. Clears count and err; the address returns to BASE_ADDR.
- in_ready = (state == RUN). A transfer occurs when in_valid && in_ready.
- RUN, transfer, legal, in_last=0 → stay in RUN. Transfer with in_last=1 → DRAIN. DRAIN → DONE after one cycle, once the last write has issued.
- RUN, illegal transfer → ERR. The word is not written and count is unchanged.
- Illegal conditions:
  - class 6–7.
  - I/LOAD/STORE imm outside [-2048, 2047].
  - BRANCH imm outside [-4096, 4094] or imm[0]=1.
  - JUMP imm[0]=1.
  - Transfer when count == 2^ADDR_W (full).
- Encoding, with imm taken in two's complement:
  - ALU_R: funct7|rs2|rs1|f3|rd|0110011.
  - ALU_I: imm[11:0]|rs1|f3|rd|0010011.
  - LOAD: as ALU_I with opcode 0000011.
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011.
  - BRANCH_EQ: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011.
  - JUMP: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Unused fields are ignored.
- Address: imem_addr = (BASE_ADDR + count) mod 2^ADDR_W. Wrap-around is permitted; only count reaching full is an error.
- `start` while in RUN or DRAIN is ignored. in_valid outside RUN is ignored.

## Timing
- Reset values: state IDLE, in_ready 0, imem_wen 0, imem_addr 0, imem_wdata 0, count 0, done 0, err 0.
- Latency is one cycle. A transfer at edge N drives imem_wen=1 with addr/wdata for the cycle after N, and count increments at the same edge N.
- Throughput is one word per cycle. Back-to-back transfers produce consecutive addresses.
- done=1 exactly while in DONE. err=1 from the edge following an illegal transfer until `start`.
- Asynchronous reset mid-program:
  - All outputs drop to reset values immediately.
  - A pending write is abandoned; imem_wen goes low in the same cycle.
- The cycle that sees start=1 has in_ready=0, so the first accept is possible one cycle later.

## Structure
- Package `instr_enc_pkg` holds:
  - class codes (CLS_ALU_R … CLS_STORE);
  - the 7-bit opcodes (shared with the control unit);
  - the FSM state enum;
  - immediate range constants.
- Sub-module `instr_field_pack` is purely combinational: fields in, 32-bit word and `illegal` flag out.
- The top level holds the FSM, the count/address register and the output register stage.

## Test plan
- start; ALU_I rd=1 rs1=0 f3=0 imm=5 → imem_wdata 0x00500093 at addr 0; count=1.
- Back-to-back stream:
  - Stimulus:
    - ALU_R rd=3 rs1=1 rs2=2 f3=0 f7=0;
    - BRANCH_EQ rs1=1 rs2=2 imm=-8;
    - JUMP rd=1 imm=8, in_last.
  - Required response:
    - words 0x002081B3, 0xFE208CE3, 0x008000EF at addrs 0–2, one per cycle;
    - done=1 two cycles after the last accept.
- LOAD rd=5 rs1=2 f3=2 imm=12 → 0x00C12283; STORE rs2=5 rs1=2 f3=2 imm=8 → 0x00512423.
- Illegal inputs, each from a fresh start:
  - Stimulus: BRANCH imm=3; ALU_I imm=2048; class=7.
  - Required response: no imem_wen, err=1, in_ready=0, count unchanged; next start clears err.
- ADDR_W=2, BASE_ADDR=2:
  - Stimulus: 4 legal words, then a 5th word.
  - Required response: the 4 words go to addrs 2, 3, 0, 1; the 5th → err, not written.
- Reset mid-program: assert arst while imem_wen=1 → imem_wen 0 immediately, state IDLE, count 0.
